branch_pc_unit: RTL and testbench

Program-counter and control-flow resolution block for the single-issue MIPS datapath. It consumes the 3-bit BranchJump code produced by the opcode decoder, together with the ALU Zero flag and the rs operand, and decides whether a branch or jump is taken. It owns the PC register, generates the fetch address, issues a one-cycle pipeline flush on redirect, produces the jal link write, and keeps a saturating count of taken redirects.

---
 rtl/branch_pc_unit.sv | 116 +++++++++++
 tb/tb_branch_pc_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: PC register, branch/jump resolution, flush and jal link.
// Redirects take one cycle; the squashed slot after a redirect is ignored.
module branch_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Stall,
    input  logic        BrValid,
    input  logic [2:0]  BranchJump,
    input  logic        IsJal,
    input  logic        RtField0,
    input  logic        Zero,
    input  logic [31:0] RsData,
    input  logic [31:0] BranchPC,
    input  logic [31:0] BranchOffset,
    input  logic [25:0] JumpIndex,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        Flush,
    output logic        LinkWrite,
    output logic [31:0] LinkAddr,
    output logic [15:0] TakenCount
);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    localparam logic [2:0] BJ_NONE   = 3'b000;
    localparam logic [2:0] BJ_BEQ    = 3'b001;
    localparam logic [2:0] BJ_BNE    = 3'b010;
    localparam logic [2:0] BJ_JUMP   = 3'b011;
    localparam logic [2:0] BJ_REGIMM = 3'b100;
    localparam logic [2:0] BJ_BGTZ   = 3'b101;
    localparam logic [2:0] BJ_BLEZ   = 3'b110;

    state_t      state;
    logic        taken;
    logic        is_jump;
    logic        do_link;
    logic        rs_neg;
    logic        rs_zero;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] target;
    logic [31:0] next_seq;

    assign rs_neg     = RsData[31];
    assign rs_zero    = (RsData == 32'h0000_0000);
    assign is_jump    = (BranchJump == BJ_JUMP);
    assign PCPlus4    = PC + 32'd4;
    assign br_target  = BranchPC + (BranchOffset << 2);
    assign jmp_target = {BranchPC[31:28], JumpIndex, 2'b00};
    assign target     = is_jump ? jmp_target : br_target;
    assign next_seq   = Stall ? PC : PCPlus4;
    assign do_link    = taken && is_jump && IsJal;

    // Only an instruction in EX during RUN may redirect; FLUSH slots are dead.
    always_comb begin
        taken = 1'b0;
        if (BrValid && state == RUN) begin
            case (BranchJump)
                BJ_NONE:   taken = 1'b0;
                BJ_BEQ:    taken = Zero;
                BJ_BNE:    taken = !Zero;
                BJ_JUMP:   taken = 1'b1;
                BJ_REGIMM: taken = RtField0 ? !rs_neg : rs_neg;
                BJ_BGTZ:   taken = !rs_neg && !rs_zero;
                BJ_BLEZ:   taken = rs_neg || rs_zero;
                default:   taken = 1'b0;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= RUN;
            PC         <= RESET_VECTOR;
            Flush      <= 1'b0;
            LinkWrite  <= 1'b0;
            LinkAddr   <= 32'h0000_0000;
            TakenCount <= 16'h0000;
        end else begin
            Flush     <= 1'b0;
            LinkWrite <= 1'b0;
            case (state)
                RUN: begin
                    if (taken) begin
                        PC    <= target;
                        Flush <= 1'b1;
                        state <= FLUSH;
                        if (TakenCount != 16'hFFFF) begin
                            TakenCount <= TakenCount + 16'd1;
                        end
                        if (do_link) begin
                            LinkWrite <= 1'b1;
                            LinkAddr  <= BranchPC;
                        end
                    end else begin
                        PC <= next_seq;
                    end
                end
                FLUSH: begin
                    PC    <= next_seq;
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed testbench for branch_pc_unit.
// Each task drives one scenario and checks outputs 1 time unit after the edge.
module tb_branch_pc_unit;

    logic        Clk;
    logic        Rst_n;
    logic        Stall;
    logic        BrValid;
    logic [2:0]  BranchJump;
    logic        IsJal;
    logic        RtField0;
    logic        Zero;
    logic [31:0] RsData;
    logic [31:0] BranchPC;
    logic [31:0] BranchOffset;
    logic [25:0] JumpIndex;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Flush;
    logic        LinkWrite;
    logic [31:0] LinkAddr;
    logic [15:0] TakenCount;

    int tests;
    int fails;
    logic [15:0] exp_cnt;

    branch_pc_unit dut (
        .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .BrValid(BrValid),
        .BranchJump(BranchJump), .IsJal(IsJal), .RtField0(RtField0),
        .Zero(Zero), .RsData(RsData), .BranchPC(BranchPC),
        .BranchOffset(BranchOffset), .JumpIndex(JumpIndex),
        .PC(PC), .PCPlus4(PCPlus4), .Flush(Flush),
        .LinkWrite(LinkWrite), .LinkAddr(LinkAddr),
        .TakenCount(TakenCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        BrValid = 1'b0; BranchJump = 3'b000; IsJal = 1'b0;
        RtField0 = 1'b0; Zero = 1'b0; RsData = 32'h0;
        BranchPC = 32'h0; BranchOffset = 32'h0; JumpIndex = 26'h0;
    endtask

    task automatic branch(input logic [2:0] bj, input logic [31:0] bpc,
                          input logic [31:0] off);
        BrValid = 1'b1; BranchJump = bj; BranchPC = bpc; BranchOffset = off;
    endtask

    task automatic test_reset();
        logic [31:0] seq [5];
        seq[0] = 32'h0; seq[1] = 32'h4; seq[2] = 32'h8;
        seq[3] = 32'hC; seq[4] = 32'h10;
        Rst_n = 1'b0; Stall = 1'b0; idle();
        #2;
        tests++;
        if (PC !== 32'h0 || Flush !== 1'b0 || LinkWrite !== 1'b0 ||
            LinkAddr !== 32'h0 || TakenCount !== 16'h0) begin
            fails++;
            $display("FAIL reset_state: pc=%h fl=%b lw=%b la=%h cnt=%h want 0",
                     PC, Flush, LinkWrite, LinkAddr, TakenCount);
        end
        tick();
        tests++;
        if (PC !== 32'h0) begin
            fails++;
            $display("FAIL reset_hold: pc=%h want 0", PC);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            tests++;
            if (PC !== seq[i] || Flush !== 1'b0 || TakenCount !== 16'h0) begin
                fails++;
                $display("FAIL free_run_%0d: pc=%h fl=%b cnt=%h want pc=%h",
                         i, PC, Flush, TakenCount, seq[i]);
            end
        end
        tests++;
        if (PCPlus4 !== 32'h14) begin
            fails++;
            $display("FAIL pcplus4: got %h want 00000014", PCPlus4);
        end
    endtask

    task automatic test_beq();
        branch(3'b001, 32'h104, 32'hFFFF_FFFE); Zero = 1'b1;
        tick(); exp_cnt++;
        tests++;
        if (PC !== 32'hFC || Flush !== 1'b1 || TakenCount !== exp_cnt) begin
            fails++;
            $display("FAIL beq_taken: pc=%h fl=%b cnt=%h want fc 1 %h",
                     PC, Flush, TakenCount, exp_cnt);
        end
        idle(); tick();
        tests++;
        if (PC !== 32'h100 || Flush !== 1'b0) begin
            fails++;
            $display("FAIL beq_flush_end: pc=%h fl=%b want 100 0", PC, Flush);
        end
        branch(3'b001, 32'h104, 32'hFFFF_FFFE); Zero = 1'b0;
        tick();
        tests++;
        if (PC !== 32'h104 || Flush !== 1'b0 || TakenCount !== exp_cnt) begin
            fails++;
            $display("FAIL beq_not_taken: pc=%h fl=%b cnt=%h want 104 0 %h",
                     PC, Flush, TakenCount, exp_cnt);
        end
        branch(3'b111, 32'h104, 32'h8); Zero = 1'b1; RsData = 32'h0;
        tick();
        tests++;
        if (PC !== 32'h108 || Flush !== 1'b0) begin
            fails++;
            $display("FAIL reserved_code: pc=%h fl=%b want 108 0", PC, Flush);
        end
        branch(3'b000, 32'h104, 32'h8);
        tick();
        tests++;
        if (PC !== 32'h10C || Flush !== 1'b0) begin
            fails++;
            $display("FAIL none_code: pc=%h fl=%b want 10c 0", PC, Flush);
        end
        idle();
    endtask

    task automatic test_jal();
        branch(3'b011, 32'h4000_0010, 32'h0);
        IsJal = 1'b1; JumpIndex = 26'h000_0040;
        tick(); exp_cnt++;
        tests++;
        if (PC !== 32'h4000_0100 || Flush !== 1'b1 || LinkWrite !== 1'b1 ||
            LinkAddr !== 32'h4000_0010 || TakenCount !== exp_cnt) begin
            fails++;
            $display("FAIL jal_taken: pc=%h fl=%b lw=%b la=%h cnt=%h",
                     PC, Flush, LinkWrite, LinkAddr, TakenCount);
        end
        idle(); tick();
        tests++;
        if (PC !== 32'h4000_0104 || Flush !== 1'b0 || LinkWrite !== 1'b0) begin
            fails++;
            $display("FAIL jal_end: pc=%h fl=%b lw=%b want 40000104 0 0",
                     PC, Flush, LinkWrite);
        end
        branch(3'b001, 32'h4000_0010, 32'h4); IsJal = 1'b1; Zero = 1'b1;
        tick(); exp_cnt++;
        tests++;
        if (PC !== 32'h4000_0020 || LinkWrite !== 1'b0) begin
            fails++;
            $display("FAIL isjal_ignored: pc=%h lw=%b want 40000020 0",
                     PC, LinkWrite);
        end
        idle(); tick();
    endtask

    task automatic test_sign();
        branch(3'b101, 32'h200, 32'h4); RsData = 32'h0;
        tick();
        tests++;
        if (PC !== 32'h4000_0028 || Flush !== 1'b0) begin
            fails++;
            $display("FAIL bgtz_zero: pc=%h fl=%b want 40000028 0", PC, Flush);
        end
        branch(3'b110, 32'h200, 32'h4); RsData = 32'h0;
        tick(); exp_cnt++;
        tests++;
        if (PC !== 32'h210 || Flush !== 1'b1 || TakenCount !== exp_cnt) begin
            fails++;
            $display("FAIL blez_zero: pc=%h fl=%b cnt=%h want 210 1 %h",
                     PC, Flush, TakenCount, exp_cnt);
        end
        idle(); tick();
        branch(3'b100, 32'h300, 32'h1); RsData = 32'h8000_0000;
        RtField0 = 1'b0;
        tick(); exp_cnt++;
        tests++;
        if (PC !== 32'h304 || Flush !== 1'b1 || TakenCount !== exp_cnt) begin
            fails++;
            $display("FAIL bltz_neg: pc=%h fl=%b cnt=%h want 304 1 %h",
                     PC, Flush, TakenCount, exp_cnt);
        end
        idle(); tick();
        branch(3'b100, 32'h300, 32'h1); RsData = 32'h8000_0000;
        RtField0 = 1'b1;
        tick();
        tests++;
        if (PC !== 32'h30C || Flush !== 1'b0 || TakenCount !== exp_cnt) begin
            fails++;
            $display("FAIL bgez_neg: pc=%h fl=%b cnt=%h want 30c 0 %h",
                     PC, Flush, TakenCount, exp_cnt);
        end
        branch(3'b101, 32'h300, 32'h2); RsData = 32'h0000_0001;
        tick(); exp_cnt++;
        tests++;
        if (PC !== 32'h308 || Flush !== 1'b1) begin
            fails++;
            $display("FAIL bgtz_pos: pc=%h fl=%b want 308 1", PC, Flush);
        end
        idle(); tick();
    endtask

    task automatic test_back_to_back();
        branch(3'b011, 32'h1000_0000, 32'h0); JumpIndex = 26'h100;
        tick(); exp_cnt++;
        branch(3'b001, 32'h500, 32'h0); Zero = 1'b1;
        tick();
        tests++;
        if (PC !== 32'h1000_0404 || Flush !== 1'b0 || TakenCount !== exp_cnt) begin
            fails++;
            $display("FAIL b2b_second_ignored: pc=%h fl=%b cnt=%h want 10000404 0 %h",
                     PC, Flush, TakenCount, exp_cnt);
        end
        idle(); Stall = 1'b1;
        tick();
        tests++;
        if (PC !== 32'h1000_0404) begin
            fails++;
            $display("FAIL stall_hold: pc=%h want 10000404", PC);
        end
        branch(3'b001, 32'h600, 32'h2); Zero = 1'b1;
        tick(); exp_cnt++;
        tests++;
        if (PC !== 32'h608 || Flush !== 1'b1 || TakenCount !== exp_cnt) begin
            fails++;
            $display("FAIL stall_redirect: pc=%h fl=%b cnt=%h want 608 1 %h",
                     PC, Flush, TakenCount, exp_cnt);
        end
        idle(); tick();
        tests++;
        if (PC !== 32'h608 || Flush !== 1'b0) begin
            fails++;
            $display("FAIL stall_in_flush: pc=%h fl=%b want 608 0", PC, Flush);
        end
        Stall = 1'b0;
    endtask

    task automatic test_wrap();
        branch(3'b001, 32'hFFFF_FFF8, 32'h1); Zero = 1'b1;
        tick(); exp_cnt++;
        idle(); tick();
        tests++;
        if (PC !== 32'h0000_0000) begin
            fails++;
            $display("FAIL pc_wrap: pc=%h want 00000000", PC);
        end
        branch(3'b010, 32'h10, 32'hFFFF_FFF8); Zero = 1'b0;
        tick(); exp_cnt++;
        tests++;
        if (PC !== 32'hFFFF_FFF0 || TakenCount !== exp_cnt) begin
            fails++;
            $display("FAIL target_wrap: pc=%h cnt=%h want fffffff0 %h",
                     PC, TakenCount, exp_cnt);
        end
        idle(); tick();
    endtask

    task automatic test_saturate();
        int n;
        n = 65535 - int'(exp_cnt);
        branch(3'b011, 32'h0, 32'h0); JumpIndex = 26'h0;
        for (int i = 0; i < n; i++) begin
            tick(); tick();
        end
        tests++;
        if (TakenCount !== 16'hFFFF) begin
            fails++;
            $display("FAIL count_reach_max: cnt=%h want ffff", TakenCount);
        end
        tick(); tick(); tick();
        tests++;
        if (TakenCount !== 16'hFFFF || Flush !== 1'b1) begin
            fails++;
            $display("FAIL count_saturate: cnt=%h fl=%b want ffff 1",
                     TakenCount, Flush);
        end
        IsJal = 1'b1;
        tick(); tick();
        tests++;
        if (LinkWrite !== 1'b1 || Flush !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_flush: lw=%b fl=%b want 1 1",
                     LinkWrite, Flush);
        end
        #2;
        Rst_n = 1'b0;
        #1;
        tests++;
        if (PC !== 32'h0 || Flush !== 1'b0 || LinkWrite !== 1'b0 ||
            LinkAddr !== 32'h0 || TakenCount !== 16'h0) begin
            fails++;
            $display("FAIL async_reset: pc=%h fl=%b lw=%b la=%h cnt=%h want 0",
                     PC, Flush, LinkWrite, LinkAddr, TakenCount);
        end
        idle();
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();
        tests++;
        if (PC !== 32'h4 || Flush !== 1'b0 || TakenCount !== 16'h0) begin
            fails++;
            $display("FAIL post_reset_run: pc=%h fl=%b cnt=%h want 4 0 0",
                     PC, Flush, TakenCount);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_cnt = 16'h0;
        test_reset();
        test_beq();
        test_jal();
        test_sign();
        test_back_to_back();
        test_wrap();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
